// File: rtl/svfloat_unpacker.sv
// IEEE-style float unpacker: classifies the operand and produces a sign, an unbiased
// exponent and an explicit-leading-one mantissa. Denormals are normalised one bit per cycle.
package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;
endpackage

module svfloat_unpacker #(
  parameter type float  = svfloat::float32,
  parameter int  ewidth = 10,
  parameter int  width  = 24,
  parameter int  frac   = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$bits(float)-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     is_inf,
  output logic                     is_nan,
  output logic                     is_snan,
  output logic                     is_zero,
  output logic                     d_sign,
  output logic signed [ewidth-1:0] d_exp,
  output logic [width-1:0]         d_man,
  output logic [1:0]               dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds valid/data until that edge, and ready never depends on valid.

  float in_f;
  assign in_f = float'(in_data);

  localparam int EB = $bits(in_f.exponent);
  localparam int MB = $bits(in_f.mantissa);
  localparam logic signed [ewidth-1:0] BIAS = ewidth'((1 << (EB - 1)) - 1);

  if (ewidth < EB + 2) begin : g_bad_ewidth
    $error("svfloat_unpacker: ewidth too small for the exponent field");
  end
  if (width != MB + 1) begin : g_bad_width
    $error("svfloat_unpacker: width must be mantissa bits + 1");
  end
  if (frac != MB) begin : g_bad_frac
    $error("svfloat_unpacker: frac must equal mantissa bits");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd2} state_t;

  state_t                     state, state_n;
  logic                       inf_n, nan_n, snan_n, zero_n, sign_n;
  logic signed [ewidth-1:0]   exp_n;
  logic [width-1:0]           man_n;
  logic                       accept;
  logic                       e_ones, e_zero, m_zero;

  assign dbg_state = state;
  assign out_valid = (state == DONE);
  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;

  assign e_ones = &in_f.exponent;
  assign e_zero = ~|in_f.exponent;
  assign m_zero = ~|in_f.mantissa;

  always_comb begin
    state_n = state;
    inf_n   = is_inf;
    nan_n   = is_nan;
    snan_n  = is_snan;
    zero_n  = is_zero;
    sign_n  = d_sign;
    exp_n   = d_exp;
    man_n   = d_man;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          inf_n   = 1'b0;
          nan_n   = 1'b0;
          snan_n  = 1'b0;
          zero_n  = 1'b0;
          sign_n  = in_f.sign;
          exp_n   = '0;
          man_n   = '0;
          state_n = DONE;
          if (e_ones && m_zero) begin
            inf_n = 1'b1;
          end else if (e_ones) begin
            nan_n  = 1'b1;
            snan_n = ~in_f.mantissa[MB-1];
            man_n  = width'({1'b0, in_f.mantissa});
          end else if (e_zero && m_zero) begin
            zero_n = 1'b1;
          end else if (e_zero) begin
            // Denormal: start at the minimum exponent and let NORM shift in the hidden one.
            exp_n   = ewidth'(1) - BIAS;
            man_n   = width'({1'b0, in_f.mantissa});
            state_n = NORM;
          end else begin
            exp_n = ewidth'(in_f.exponent) - BIAS;
            man_n = width'({1'b1, in_f.mantissa});
          end
        end else if (state == DONE && out_ready) begin
          state_n = IDLE;
        end
      end
      NORM: begin
        man_n = d_man << 1;
        exp_n = d_exp - ewidth'(1);
        if (d_man[width-2]) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      is_inf  <= 1'b0;
      is_nan  <= 1'b0;
      is_snan <= 1'b0;
      is_zero <= 1'b0;
      d_sign  <= 1'b0;
      d_exp   <= '0;
      d_man   <= '0;
    end else begin
      state   <= state_n;
      is_inf  <= inf_n;
      is_nan  <= nan_n;
      is_snan <= snan_n;
      is_zero <= zero_n;
      d_sign  <= sign_n;
      d_exp   <= exp_n;
      d_man   <= man_n;
    end
  end

endmodule
